bilinear_interp_pipe: RTL and testbench
=======================================

BILINEAR_INTERP_PIPE -- requirements
Module: bilinear_interp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel bit width.
REQ-002 SHALL have parameter FRAC, default 8: fractional bits of coordinates, weights and result.
REQ-003 SHALL have parameter COORD, default 8: integer bits of coordinates.
REQ-004 SHALL have parameter ROUND, default 0: 0 = truncate final shift, 1 = round-half-up.
REQ-005 SHALL have parameter TAG_W, default 4: width of the user tag passed through.
REQ-006 SHALL use one clock and a synchronous, active-high reset; the ports are i_clk and i_rst.
REQ-007 SHALL have i_clk  in  1  clock; all state is updated on the rising edge.
REQ-008 SHALL have i_rst  in  1  synchronous active-high reset.
REQ-009 SHALL have i_valid  in  1  input beat valid.
REQ-010 SHALL have o_ready  out  1  input beat accepted when i_valid && o_ready.
REQ-011 SHALL have i_pixel_00, i_pixel_01, i_pixel_10, i_pixel_11  in  WIDTH each  2x2 neighbourhood (row, column).
REQ-012 SHALL have i_x_ori, i_y_ori  in  COORD each  integer origin of the neighbourhood.
REQ-013 SHALL have i_x_ne, i_y_ne  in  COORD+FRAC each  unsigned fixed-point target coordinate.
REQ-014 SHALL have i_tag  in  TAG_W  user sideband.
REQ-015 SHALL have o_valid  out  1  result valid.
REQ-016 SHALL have i_ready  in  1  downstream accepts the result when o_valid && i_ready.
REQ-017 SHALL have o_result  out  WIDTH+FRAC  interpolated value in unsigned Q(WIDTH).(FRAC) format.
REQ-018 SHALL have o_clamp  out  1  the beat's dx or dy was clamped.
REQ-019 SHALL have o_tag  out  TAG_W  i_tag of the same beat.

Function
REQ-020 SHALL be a 3-stage pipeline (S1 weights, S2 horizontal lerp, S3 vertical lerp plus output register), giving a latency of 3 accepted cycles.
REQ-021 SHALL use a global enable en = !o_valid || i_ready, and SHALL drive o_ready = en.
REQ-022 SHALL leave all stage registers, valids and outputs unchanged when en=0.
REQ-023 SHALL advance each stage valid from the previous stage when en=1, with S1 valid loaded from i_valid.
REQ-024 SHALL, in S1, compute dx = i_x_ne - (i_x_ori << FRAC) as a signed value of COORD+FRAC+1 bits; dy is computed the same way from the y inputs.
REQ-025 SHALL clamp dx below 0 to 0 and dx above ONE = 2^FRAC to ONE; dy SHALL clamp the same way.
REQ-026 SHALL set the beat's clamp flag if either dx or dy was clamped; the flag is carried with the beat to o_clamp.
REQ-027 SHALL, in S2, compute r0 = p00*(ONE-dx) + p01*dx and r1 = p10*(ONE-dx) + p11*dx at full WIDTH+FRAC width, with no truncation.
REQ-028 SHALL, in S3, compute R = r0*(ONE-dy) + r1*dy at WIDTH+2*FRAC width, with no overflow for any input.
REQ-029 SHALL set o_result = R >> FRAC when ROUND=0, and (R + 2^(FRAC-1)) >> FRAC when ROUND=1.
REQ-030 SHALL saturate the rounded o_result to all-ones when it would overflow.
REQ-031 SHALL deliver dx=ONE exactly as the right column (p01/p11), and dy=ONE as the bottom row.
REQ-032 SHALL carry the tag and clamp flag in lockstep with the data, so beat order is preserved.
REQ-033 SHALL neither drop nor duplicate beats under any i_valid/i_ready pattern.
REQ-034 SHALL hold o_result, o_tag and o_clamp stable while o_valid && !i_ready.
REQ-035 SHALL sustain a throughput of one beat per cycle when i_ready is held at 1.

Reset
REQ-036 SHALL, while i_rst=1, clear all stage valids and o_valid, and drive o_result=0, o_clamp=0 and o_tag=0.
REQ-037 SHALL drive o_ready=1 in the first cycle after reset deasserts.
REQ-038 SHALL discard in-flight beats when reset is asserted mid-stream, and SHALL not emit them after release.
REQ-039 SHALL ignore i_valid while i_rst=1.

Verification
REQ-040 SHALL pass the basic case (WIDTH=FRAC=COORD=8, ROUND=0): p=10,20,30,40, x_ori=5, x_ne=0x0580, y_ori=3, y_ne=0x0340, tag=0xA -> 3 cycles later o_valid=1, o_result=0x001400 (20.0), o_clamp=0, o_tag=0xA.
REQ-041 SHALL pass the corners: dx=dy=0 with p00=0xFF -> 0x00FF00; x_ne=(x_ori+1)<<8 and y_ne=y_ori<<8 with p01=0x7F -> 0x007F00.
REQ-042 SHALL pass the clamp case: x_ne = (x_ori<<8) - 1 with p00=50 and dy=0 -> o_result=0x003200, o_clamp=1; y_ne = (y_ori+2)<<8 -> bottom-row value, o_clamp=1.
REQ-043 SHALL pass the rounding case: only p01=1, dx=3, dy=5 -> ROUND=0 gives 0x000002 and ROUND=1 gives 0x000003.
REQ-044 SHALL pass backpressure: with 6 back-to-back beats and i_ready=0 for 5 cycles, o_ready drops, o_result is held, and all 6 beats arrive in order with the correct tags.
REQ-045 SHALL pass mid-stream reset: 1-cycle i_rst with 2 beats in flight -> no output from those beats, o_valid=0, and the next beat's result arrives 3 cycles after acceptance.

Source files
------------

// File: rtl/bilinear_interp_pipe.sv
// Bilinear interpolation pipeline.
//
// Takes a 2x2 pixel neighbourhood, the integer origin of that neighbourhood and an unsigned
// fixed-point target coordinate, and produces the bilinearly interpolated value in unsigned
// Q(WIDTH).(FRAC) format. Three register stages:
//   S1: fractional offsets dx/dy (clamped to [0, ONE]) and clamp flag
//   S2: horizontal lerp of the top and bottom rows (full precision)
//   S3: vertical lerp, optional round-half-up, saturation, output register
// A single global enable stalls every stage together when the output is held.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_valid / o_ready                 input handshake
//   i_pixel_00/01/10/11               neighbourhood pixels, indexed (row, column)
//   i_x_ori, i_y_ori                  integer origin of the neighbourhood
//   i_x_ne, i_y_ne                    fixed-point target coordinate (COORD.FRAC)
//   i_tag                             user sideband, carried with the beat
//   o_valid / i_ready                 output handshake
//   o_result                          interpolated value, Q(WIDTH).(FRAC)
//   o_clamp                           dx or dy of this beat was clamped
//   o_tag                             i_tag of this beat
module bilinear_interp_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned COORD = 8,
  parameter int unsigned ROUND = 0,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [WIDTH-1:0]        i_pixel_00,
  input  logic [WIDTH-1:0]        i_pixel_01,
  input  logic [WIDTH-1:0]        i_pixel_10,
  input  logic [WIDTH-1:0]        i_pixel_11,
  input  logic [COORD-1:0]        i_x_ori,
  input  logic [COORD-1:0]        i_y_ori,
  input  logic [COORD+FRAC-1:0]   i_x_ne,
  input  logic [COORD+FRAC-1:0]   i_y_ne,
  input  logic [TAG_W-1:0]        i_tag,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH+FRAC-1:0]   o_result,
  output logic                    o_clamp,
  output logic [TAG_W-1:0]        o_tag
);

  // Signed offset width, weight width (0..ONE inclusive), row width, accumulator width.
  localparam int unsigned DW = COORD + FRAC + 1;
  localparam int unsigned WW = FRAC + 1;
  localparam int unsigned RW = WIDTH + FRAC;
  localparam int unsigned AW = WIDTH + 2 * FRAC;

  localparam logic [WW-1:0]        ONE   = {1'b1, {FRAC{1'b0}}};
  localparam logic signed [DW-1:0] ONE_D = DW'(1) << FRAC;
  localparam logic [AW:0]          RND_ADD = (ROUND != 0) ? ((AW + 1)'(1) << (FRAC - 1)) : '0;

  // Every stage moves together; nothing advances while a result waits for downstream.
  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // ---------------------------------------------------------------------------------------------
  // S1: offsets from the neighbourhood origin, clamped to [0, ONE]
  // ---------------------------------------------------------------------------------------------
  logic signed [DW-1:0] dx_raw, dy_raw;
  logic [WW-1:0]        dx_w, dy_w;
  logic                 dx_c, dy_c;

  assign dx_raw = $signed({1'b0, i_x_ne}) - $signed({1'b0, i_x_ori, {FRAC{1'b0}}});
  assign dy_raw = $signed({1'b0, i_y_ne}) - $signed({1'b0, i_y_ori, {FRAC{1'b0}}});

  always_comb begin
    dx_w = dx_raw[WW-1:0];
    dx_c = 1'b0;
    if (dx_raw[DW-1]) begin
      dx_w = '0;
      dx_c = 1'b1;
    end else if (dx_raw > ONE_D) begin
      dx_w = ONE;
      dx_c = 1'b1;
    end
  end

  always_comb begin
    dy_w = dy_raw[WW-1:0];
    dy_c = 1'b0;
    if (dy_raw[DW-1]) begin
      dy_w = '0;
      dy_c = 1'b1;
    end else if (dy_raw > ONE_D) begin
      dy_w = ONE;
      dy_c = 1'b1;
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p00, s1_p01, s1_p10, s1_p11;
  logic [WW-1:0]    s1_dx, s1_dy;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_clamp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_p00   <= '0;
      s1_p01   <= '0;
      s1_p10   <= '0;
      s1_p11   <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_tag   <= '0;
      s1_clamp <= 1'b0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_p00   <= i_pixel_00;
      s1_p01   <= i_pixel_01;
      s1_p10   <= i_pixel_10;
      s1_p11   <= i_pixel_11;
      s1_dx    <= dx_w;
      s1_dy    <= dy_w;
      s1_tag   <= i_tag;
      s1_clamp <= dx_c | dy_c;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S2: horizontal lerp. Each product is at most (2^WIDTH-1)*ONE and the two weights sum to
  // ONE, so the exact row value always fits RW bits.
  // ---------------------------------------------------------------------------------------------
  logic [WW-1:0] inv_dx;
  logic [RW-1:0] r0, r1;

  assign inv_dx = ONE - s1_dx;
  assign r0     = RW'(s1_p00) * RW'(inv_dx) + RW'(s1_p01) * RW'(s1_dx);
  assign r1     = RW'(s1_p10) * RW'(inv_dx) + RW'(s1_p11) * RW'(s1_dx);

  logic             s2_valid;
  logic [RW-1:0]    s2_r0, s2_r1;
  logic [WW-1:0]    s2_dy;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_clamp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_r0    <= '0;
      s2_r1    <= '0;
      s2_dy    <= '0;
      s2_tag   <= '0;
      s2_clamp <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_r0    <= r0;
      s2_r1    <= r1;
      s2_dy    <= s1_dy;
      s2_tag   <= s1_tag;
      s2_clamp <= s1_clamp;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S3: vertical lerp, rounding and saturation. The rounding add gets one spare bit; anything
  // left above RW after the shift means the result would not fit and is saturated.
  // ---------------------------------------------------------------------------------------------
  logic [WW-1:0] inv_dy;
  logic [AW-1:0] acc;
  logic [AW:0]   acc_rnd;
  logic [AW:0]   shifted;
  logic [RW-1:0] result_d;

  assign inv_dy  = ONE - s2_dy;
  assign acc     = AW'(s2_r0) * AW'(inv_dy) + AW'(s2_r1) * AW'(s2_dy);
  assign acc_rnd = {1'b0, acc} + RND_ADD;
  assign shifted = acc_rnd >> FRAC;

  always_comb begin
    result_d = shifted[RW-1:0];
    if (|shifted[AW:RW]) begin
      result_d = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
      o_clamp  <= 1'b0;
    end else if (en) begin
      o_valid  <= s2_valid;
      o_result <= result_d;
      o_tag    <= s2_tag;
      o_clamp  <= s2_clamp;
    end
  end

endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Self-checking bench for bilinear_interp_pipe. Two instances share all inputs: one truncating
// (ROUND=0) and one rounding (ROUND=1). A reference model computes each accepted beat's
// expected result from the weighted-sum definition of bilinear interpolation; a compare
// process pops those expectations as results are consumed and also checks the handshake,
// hold and reset rules every cycle.
module tb_bilinear_interp_pipe;

  localparam int W  = 8;
  localparam int F  = 8;
  localparam int TW = 4;
  localparam int ONE = 1 << F;

  logic          i_clk;
  logic          i_rst;
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  p00, p01, p10, p11;
  logic [7:0]    x_ori, y_ori;
  logic [15:0]   x_ne, y_ne;
  logic [TW-1:0] tag;

  logic          o_ready, o_valid, o_clamp;
  logic [15:0]   o_result;
  logic [TW-1:0] o_tag;
  logic          o_ready_r, o_valid_r, o_clamp_r;
  logic [15:0]   o_result_r;
  logic [TW-1:0] o_tag_r;

  bilinear_interp_pipe #(.WIDTH(W), .FRAC(F), .COORD(8), .ROUND(0), .TAG_W(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_pixel_00(p00), .i_pixel_01(p01), .i_pixel_10(p10), .i_pixel_11(p11),
    .i_x_ori(x_ori), .i_y_ori(y_ori), .i_x_ne(x_ne), .i_y_ne(y_ne), .i_tag(tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_clamp(o_clamp),
    .o_tag(o_tag)
  );

  bilinear_interp_pipe #(.WIDTH(W), .FRAC(F), .COORD(8), .ROUND(1), .TAG_W(TW)) dut_r (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_r),
    .i_pixel_00(p00), .i_pixel_01(p01), .i_pixel_10(p10), .i_pixel_11(p11),
    .i_x_ori(x_ori), .i_y_ori(y_ori), .i_x_ne(x_ne), .i_y_ne(y_ne), .i_tag(tag),
    .o_valid(o_valid_r), .i_ready(i_ready), .o_result(o_result_r), .o_clamp(o_clamp_r),
    .o_tag(o_tag_r)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int res_t;
    int res_r;
    int tag;
    bit clamp;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Bilinear interpolation as a single weighted sum of the four corners, scaled by ONE^2.
  function automatic void model(input int a, b, c, d, xo, xn, yo, yn,
                                output int res_t, output int res_r, output bit clamp);
    int     dx, dy;
    longint num, lim;
    dx    = xn - xo * ONE;
    dy    = yn - yo * ONE;
    clamp = 0;
    if (dx < 0)   begin dx = 0;   clamp = 1; end
    if (dx > ONE) begin dx = ONE; clamp = 1; end
    if (dy < 0)   begin dy = 0;   clamp = 1; end
    if (dy > ONE) begin dy = ONE; clamp = 1; end
    num = longint'(a) * (ONE - dx) * (ONE - dy) + longint'(b) * dx * (ONE - dy)
        + longint'(c) * (ONE - dx) * dy + longint'(d) * dx * dy;
    lim   = (longint'(1) << (W + F)) - 1;
    res_t = int'((num / ONE > lim) ? lim : num / ONE);
    res_r = int'(((num + ONE / 2) / ONE > lim) ? lim : (num + ONE / 2) / ONE);
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Compare process: sampled on the falling edge, between driving and the next rising edge.
  // ---------------------------------------------------------------------------------------------
  bit            prev_rst   = 0;
  bit            prev_stall = 0;
  bit            saw_low    = 0;
  logic [15:0]   held_res, held_res_r;
  logic [TW-1:0] held_tag;
  logic          held_clamp;

  always @(negedge i_clk) begin
    if (prev_rst) begin
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_result", 32'(o_result), 32'd0);
      chk("rst_o_tag", 32'(o_tag), 32'd0);
      chk("rst_o_clamp", 32'(o_clamp), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd1);
    end
    if (i_rst) begin
      q.delete();
      prev_stall = 0;
    end else begin
      if (o_ready === 1'b0) saw_low = 1;
      chk("ready_rule", 32'(o_ready), 32'(!o_valid || i_ready));
      chk("valid_pair", 32'(o_valid_r), 32'(o_valid));
      if (prev_stall) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_result", 32'(o_result), 32'(held_res));
        chk("hold_result_r", 32'(o_result_r), 32'(held_res_r));
        chk("hold_tag", 32'(o_tag), 32'(held_tag));
        chk("hold_clamp", 32'(o_clamp), 32'(held_clamp));
      end
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got o_valid=1 tag 0x%0h, want no beat", o_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result_trunc", 32'(o_result), 32'(e.res_t));
          chk("result_round", 32'(o_result_r), 32'(e.res_r));
          chk("tag", 32'(o_tag), 32'(e.tag));
          chk("clamp", 32'(o_clamp), 32'(e.clamp));
          chk("clamp_r", 32'(o_clamp_r), 32'(e.clamp));
        end
      end
      prev_stall = (o_valid === 1'b1) && (i_ready === 1'b0);
      held_res   = o_result;
      held_res_r = o_result_r;
      held_tag   = o_tag;
      held_clamp = o_clamp;
      if (i_valid === 1'b1 && o_ready === 1'b1) begin
        exp_t e;
        model(int'(p00), int'(p01), int'(p10), int'(p11), int'(x_ori), int'(x_ne),
              int'(y_ori), int'(y_ne), e.res_t, e.res_r, e.clamp);
        e.tag = int'(tag);
        q.push_back(e);
      end
    end
    prev_rst = i_rst;
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------------
  task automatic send(input int a, b, c, d, xo, xn, yo, yn, tg);
    int n;
    bit acc;
    p00 = 8'(a); p01 = 8'(b); p10 = 8'(c); p11 = 8'(d);
    x_ori = 8'(xo); x_ne = 16'(xn); y_ori = 8'(yo); y_ne = 16'(yn);
    tag = TW'(tg);
    i_valid = 1'b1;
    n   = 0;
    acc = 0;
    while (!acc && n < 200) begin
      @(negedge i_clk);
      if (o_ready === 1'b1 && !i_rst) begin
        acc     = 1;
        acc_cyc = cyc;
      end
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance in %0d cycles, want acceptance", n);
    end
    i_valid = 1'b0;
  endtask

  // Directed beat with a hand-computed expectation that also pins the model.
  task automatic send_lit(input string name, input int a, b, c, d, xo, xn, yo, yn, tg,
                          input int want_t, input int want_r, input bit want_c);
    int rt, rr;
    bit cl;
    model(a, b, c, d, xo, xn, yo, yn, rt, rr, cl);
    chk({name, "_model_trunc"}, 32'(rt), 32'(want_t));
    chk({name, "_model_round"}, 32'(rr), 32'(want_r));
    chk({name, "_model_clamp"}, 32'(cl), 32'(want_c));
    send(a, b, c, d, xo, xn, yo, yn, tg);
  endtask

  task automatic drain();
    int n;
    i_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || o_valid === 1'b1) && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  bit done;

  initial begin
    int lat, n;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    p00 = '0; p01 = '0; p10 = '0; p11 = '0;
    x_ori = '0; y_ori = '0; x_ne = '0; y_ne = '0; tag = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;

    // Directed vectors, back to back.
    send_lit("basic", 10, 20, 30, 40, 5, 'h0580, 3, 'h0340, 'hA, 'h1400, 'h1400, 0);
    send_lit("corner00", 'hFF, 0, 0, 0, 7, 'h0700, 9, 'h0900, 1, 'hFF00, 'hFF00, 0);
    send_lit("corner01", 0, 'h7F, 0, 0, 7, 'h0800, 9, 'h0900, 2, 'h7F00, 'h7F00, 0);
    send_lit("clamp_lo", 50, 0, 0, 0, 4, 'h03FF, 2, 'h0200, 3, 'h3200, 'h3200, 1);
    send_lit("clamp_bot", 11, 22, 33, 44, 4, 'h0400, 2, 'h0400, 4, 'h2100, 'h2100, 1);
    send_lit("round", 0, 1, 0, 0, 1, 'h0103, 1, 'h0105, 5, 'h0002, 'h0003, 0);
    send_lit("wide", 0, 'h5A, 0, 0, 0, 'hFFFF, 255, 'h0000, 6, 'h5A00, 'h5A00, 1);
    send_lit("full", 255, 255, 255, 255, 2, 'h0280, 2, 'h02C0, 7, 'hFF00, 'hFF00, 0);
    drain();

    // Backpressure: six back-to-back beats with the output blocked for five cycles.
    saw_low = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(10 * i, 255 - i, 3 * i, 100 + i, 6, 'h0600 + 40 * i, 8, 'h0800 + 30 * i, i + 8);
        end
      end
      begin
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ready_dropped", 32'(saw_low), 32'd1);

    // Mid-stream reset with two beats in flight; a beat offered during reset is ignored.
    send(1, 2, 3, 4, 1, 'h0180, 1, 'h0180, 'hC);
    send(5, 6, 7, 8, 1, 'h0180, 1, 'h0180, 'hD);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    tag     = 4'hF;
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      chk("mid_rst_no_output", 32'(o_valid), 32'd0);
    end
    @(posedge i_clk);
    #1;
    send(20, 40, 60, 80, 2, 'h0200, 2, 'h0200, 'hE);
    n = 0;
    lat = -1;
    while (lat < 0 && n < 20) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) lat = cyc - acc_cyc;
      n++;
    end
    chk("mid_rst_latency", 32'(lat), 32'd3);
    drain();

    // Random-ish beats with a random downstream ready pattern.
    done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          int xo, yo;
          xo = int'($urandom_range(1, 250));
          yo = int'($urandom_range(1, 250));
          send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               xo, xo * ONE + int'($urandom_range(0, 384)) - 64,
               yo, yo * ONE + int'($urandom_range(0, 384)) - 64, i);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge i_clk);
          #1;
          i_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion by time %0t, want $finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
